alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the execute stage of the pipelined core; successor to the 8-bit combinational ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv_iter.sv | 92 +++++++++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcode encoding, handshake FSM states, op classifier   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_SLT  = 4'h6;
   localparam logic [3:0] OP_SLTU = 4'h7;
   localparam logic [3:0] OP_SLL  = 4'h8;
   localparam logic [3:0] OP_SRL  = 4'h9;
   localparam logic [3:0] OP_SRA  = 4'hA;
   localparam logic [3:0] OP_PASSB = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_MULH = 4'hD;
   localparam logic [3:0] OP_DIVU = 4'hE;
   localparam logic [3:0] OP_REMU = 4'hF;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // MUL/MULH/DIVU/REMU occupy the top quarter of the opcode space
   function automatic logic is_multicycle(input logic [3:0] op);
      return op[3] & op[2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_muldiv_iter : shared shift-add multiplier / restoring divider |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   localparam int c_cnt_w = $clog2(WIDTH) + 1;

   logic               r_busy;
   logic               r_div;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_opb;
   logic [c_cnt_w-1:0] r_cnt;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_nxt_hi;
   logic [WIDTH-1:0]   w_nxt_lo;

   // Outputs expose the step being taken this cycle, so the caller can
   // register the final value on the same edge as the last iteration.
   always_comb begin
      w_sum    = {1'b0, r_hi} + {1'b0, r_opb};
      w_trial  = {r_hi, r_lo[WIDTH-1]};
      w_diff   = w_trial - {1'b0, r_opb};
      w_nxt_hi = r_hi;
      w_nxt_lo = r_lo;
      if (r_div) begin
         // divisor of zero never borrows: quotient all ones, remainder = dividend
         if (w_diff[WIDTH]) begin
            w_nxt_hi = w_trial[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], 1'b0};
         end else begin
            w_nxt_hi = w_diff[WIDTH-1:0];
            w_nxt_lo = {r_lo[WIDTH-2:0], 1'b1};
         end
      end else if (r_lo[0]) begin
         w_nxt_hi = w_sum[WIDTH:1];
         w_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
      end else begin
         w_nxt_hi = {1'b0, r_hi[WIDTH-1:1]};
         w_nxt_lo = {r_hi[0], r_lo[WIDTH-1:1]};
      end
   end

   assign done   = r_busy && (r_cnt == c_cnt_w'(WIDTH - 1));
   assign res_lo = w_nxt_lo;
   assign res_hi = w_nxt_hi;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_div  <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_opb  <= '0;
         r_cnt  <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_div  <= is_div;
         r_hi   <= '0;
         r_lo   <= a;
         r_opb  <= b;
         r_cnt  <= '0;
      end else if (r_busy) begin
         r_hi <= w_nxt_hi;
         r_lo <= w_nxt_lo;
         if (done) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_mc : multi-cycle ALU, valid/ready in, pulsed registered out   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] op,
   input  logic [WIDTH-1:0]  src_a,
   input  logic [WIDTH-1:0]  src_b,
   output logic              out_valid,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              neg,
   output logic              carry,
   output logic              ovf
);

   localparam int c_sh_w = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_sel_hi;
   logic               w_accept;
   logic               w_start;
   logic               w_finish;
   logic               w_md_done;
   logic [WIDTH-1:0]   w_md_lo;
   logic [WIDTH-1:0]   w_md_hi;
   logic [WIDTH-1:0]   w_md_res;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_dif;
   logic [c_sh_w-1:0]  w_shamt;
   logic [WIDTH-1:0]   w_sc_res;
   logic               w_sc_c;
   logic               w_sc_v;

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = (r_state == IDLE) && !reset;
      w_accept    = in_valid && in_ready;
      w_start     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && is_multicycle(op)) begin
               w_state_nxt = BUSY;
               w_start     = 1'b1;
            end
         end
         BUSY: begin
            if (w_md_done) begin
               w_state_nxt = IDLE;
               w_finish    = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_shamt  = src_b[c_sh_w-1:0];
      w_sum    = {1'b0, src_a} + {1'b0, src_b};
      w_dif    = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
      w_sc_res = '0;
      w_sc_c   = 1'b0;
      w_sc_v   = 1'b0;
      case (op)
         OP_ADD: begin
            w_sc_res = w_sum[WIDTH-1:0];
            w_sc_c   = w_sum[WIDTH];
            w_sc_v   = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_sc_res = w_dif[WIDTH-1:0];
            w_sc_c   = w_dif[WIDTH];
            w_sc_v   = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_dif[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_AND:   w_sc_res = src_a & src_b;
         OP_OR:    w_sc_res = src_a | src_b;
         OP_XOR:   w_sc_res = src_a ^ src_b;
         OP_NOR:   w_sc_res = ~(src_a | src_b);
         OP_SLT:   w_sc_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU:  w_sc_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
         OP_SLL:   w_sc_res = src_a << w_shamt;
         OP_SRL:   w_sc_res = src_a >> w_shamt;
         OP_SRA:   w_sc_res = $signed(src_a) >>> w_shamt;
         OP_PASSB: w_sc_res = src_b;
         default:  w_sc_res = '0;
      endcase
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (w_start),
      .is_div (op[1]),
      .a      (src_a),
      .b      (src_b),
      .done   (w_md_done),
      .res_lo (w_md_lo),
      .res_hi (w_md_hi)
   );

   // MULH and REMU (odd multi-cycle opcodes) take the upper half
   assign w_md_res = r_sel_hi ? w_md_hi : w_md_lo;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel_hi  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (w_start) begin
            r_sel_hi <= op[0];
         end
         if (w_accept && !is_multicycle(op)) begin
            out_valid <= 1'b1;
            result    <= w_sc_res;
            zero      <= (w_sc_res == '0);
            neg       <= w_sc_res[WIDTH-1];
            carry     <= w_sc_c;
            ovf       <= w_sc_v;
         end else if (w_finish) begin
            out_valid <= 1'b1;
            result    <= w_md_res;
            zero      <= (w_md_res == '0);
            neg       <= w_md_res[WIDTH-1];
            carry     <= 1'b0;
            ovf       <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_mc : scoreboard bench for alu_mc (WIDTH=8)                 |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_alu_mc;

   localparam int c_w = 8;

   typedef struct packed {
      logic [7:0]  res;
      logic [3:0]  flg;
      logic [31:0] due;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] op = 4'h0;
   logic [7:0] src_a = 8'h00;
   logic [7:0] src_b = 8'h00;
   logic       out_valid;
   logic [7:0] result;
   logic       zero, neg, carry, ovf;

   int         n_tests = 0;
   int         n_fail = 0;
   logic [31:0] cyc = 0;
   exp_t       sb[$];

   alu_mc #(.WIDTH(c_w), .CTRL_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      exp_t        e;
      logic [8:0]  t;
      logic [15:0] p;
      logic [7:0]  r;
      logic [2:0]  sh;
      logic        c, v;
      c  = 1'b0;
      v  = 1'b0;
      r  = 8'h00;
      sh = b[2:0];
      p  = {8'h00, a} * {8'h00, b};
      case (o)
         4'h0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8];
                     v = (a[7] == b[7]) && (t[7] != a[7]); end
         4'h1: begin t = {1'b0, a} + {1'b0, ~b} + 9'd1; r = t[7:0]; c = t[8];
                     v = (a[7] != b[7]) && (t[7] != a[7]); end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: r = ~(a | b);
         4'h6: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
         4'h7: r = (a < b) ? 8'd1 : 8'd0;
         4'h8: r = a << sh;
         4'h9: r = a >> sh;
         4'hA: r = $signed(a) >>> sh;
         4'hB: r = b;
         4'hC: r = p[7:0];
         4'hD: r = p[15:8];
         4'hE: r = (b == 8'h00) ? 8'hFF : a / b;
         default: r = (b == 8'h00) ? a : a % b;
      endcase
      e.res = r;
      e.flg = {(r == 8'h00), r[7], c, v};
      e.due = 0;
      return e;
   endfunction

   // Result checker: every out_valid pulse must match the oldest expectation, on time.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && out_valid) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("result", {24'h0, result}, {24'h0, e.res});
            check("flags_zncv", {28'h0, zero, neg, carry, ovf}, {28'h0, e.flg});
            check("out_cycle", cyc, e.due);
         end
      end
   end

   task automatic do_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("ready_timeout", 32'd0, 32'd1);
         return;
      end
      in_valid = 1'b1;
      op       = o;
      src_a    = a;
      src_b    = b;
      @(posedge clk);
      e     = model(o, a, b);
      e.due = cyc + ((o[3] & o[2]) ? 32'd9 : 32'd1);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("ready_in_reset", {31'h0, in_ready}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_ready", {31'h0, in_ready}, 32'd1);
      check("reset_outs", {20'h0, out_valid, result, zero, neg, carry, ovf}, 32'd0);

      // reset in the middle of a MUL discards it
      do_op(4'hC, 8'd15, 8'd17);
      idle(2);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("ready_mid_reset", {31'h0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {31'h0, in_ready}, 32'd1);
      check("outs_after_reset", {20'h0, out_valid, result, zero, neg, carry, ovf}, 32'd0);
      idle(12);

      do_op(4'h0, 8'h7F, 8'h01);
      do_op(4'h1, 8'h05, 8'h05);
      do_op(4'hC, 8'd15, 8'd17);
      do_op(4'hD, 8'd15, 8'd17);
      do_op(4'hC, 8'hFF, 8'hFF);

      // ready must stay low for 8 cycles; junk driven meanwhile must be ignored
      do_op(4'hD, 8'hFF, 8'hFF);
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      op       = 4'h0;
      src_a    = 8'hAA;
      src_b    = 8'h55;
      while (!in_ready && n < 20) begin
         n++;
         if (n == 4) in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("busy_cycles", n, 32'd8);

      do_op(4'hE, 8'd200, 8'd7);
      do_op(4'hF, 8'd200, 8'd7);
      do_op(4'hE, 8'h2A, 8'h00);
      do_op(4'hF, 8'h2A, 8'h00);
      do_op(4'h0, 8'h10, 8'h20);
      do_op(4'h4, 8'hF0, 8'h3C);
      do_op(4'h8, 8'h81, 8'h0B);
      idle(2);

      for (int i = 0; i < 16; i++) do_op(4'(i), 8'h02, 8'h04);
      do_op(4'hA, 8'h80, 8'h03);
      do_op(4'h6, 8'hFF, 8'h01);
      do_op(4'h7, 8'hFF, 8'h01);
      do_op(4'h0, 8'hFF, 8'h01);
      do_op(4'h1, 8'h80, 8'h01);
      idle(1);

      for (int i = 0; i < 40; i++) begin
         do_op(4'($urandom_range(0, 15)), 8'($urandom),
               ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
      end
      idle(1);

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 32'd0);
      idle(5);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
